// File: rtl/store_buffer.sv
// In-order store buffer between the core data port and a valid/ready data memory, with youngest-match load forwarding.
// Optional build macro STORE_BUFFER_COALESCE_EN merges a store into the youngest entry when the addresses match.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wvalid,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_wready,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] youngest;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic          coalesce;

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign mem_wvalid = ~empty;
  assign mem_waddr  = entries[head].addr;
  assign mem_wdata  = entries[head].data;
  assign mem_raddr  = cpu_addr;
  assign pop        = mem_wvalid & mem_wready;
  assign youngest   = tail - PW'(1);

`ifdef STORE_BUFFER_COALESCE_EN
  logic youngest_hit;
  assign youngest_hit = ~empty && (entries[youngest].addr == cpu_addr);
  // The head being drained this cycle cannot absorb a merge; full implies count>1 so stall never sees mem_wready.
  assign coalesce  = cpu_we & youngest_hit & ((count > (PW+1)'(1)) | ~pop);
  assign cpu_stall = cpu_we & full & ~youngest_hit;
`else
  assign coalesce  = 1'b0;
  assign cpu_stall = cpu_we & full;
`endif

  assign push = cpu_we & ~cpu_stall & ~coalesce;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is not reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: cpu_addr, data: cpu_wdata};
    end else if (coalesce) begin
      entries[youngest].data <= cpu_wdata;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    cpu_rdata = mem_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].addr == cpu_addr)) begin
        cpu_rdata = entries[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer, checked against a queue-based model of the buffer contents.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;
  logic          empty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; drives one cycle, checks outputs mid-cycle, then advances the model at the rising edge.
  task automatic step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
    logic [DW-1:0] exp_rd;
    bit hit, stall, pop, co;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; mem_wready = rdy;
    mem_rdata = $urandom;
    #1;
    exp_rd = mem_rdata;
    foreach (q[i]) if (q[i].addr == a) exp_rd = q[i].data;
    hit = (q.size() != 0) && (q[q.size()-1].addr == a);
`ifdef STORE_BUFFER_COALESCE_EN
    stall = we && (q.size() == DEPTH) && !hit;
`else
    stall = we && (q.size() == DEPTH);
`endif
    pop = (q.size() != 0) && rdy;
    chk("stall", 64'(cpu_stall), 64'(stall));
    chk("wvalid", 64'(mem_wvalid), 64'(q.size() != 0));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("rdata", 64'(cpu_rdata), 64'(exp_rd));
    chk("raddr", 64'(mem_raddr), 64'(a));
    if (q.size() != 0) begin
      chk("waddr", 64'(mem_waddr), 64'(q[0].addr));
      chk("wdata", 64'(mem_wdata), 64'(q[0].data));
    end
    @(posedge clk);
`ifdef STORE_BUFFER_COALESCE_EN
    co = we && hit && (q.size() > 1 || !pop);
`else
    co = 1'b0;
`endif
    if (co) q[q.size()-1].data = d;
    if (pop) void'(q.pop_front());
    if (we && !stall && !co) q.push_back('{addr: a, data: d});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_wready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wvalid", 64'(mem_wvalid), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_stall", 64'(cpu_stall), 64'(0));
    reset = 1'b1;

    // Two stores drained back to back.
    step(1, 96, 3, 1);
    step(1, 100, 7, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("drained_empty", 64'(empty), 64'(1));

    // Fill with a blocked memory, stall on the fifth, release one slot, then retry.
    for (int i = 0; i < 5; i++) step(1, 32'(i*4), 32'(i+10), 0);
    step(1, 16, 14, 1);
    step(1, 16, 14, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Forwarding picks the youngest match; a miss reads memory.
    step(1, 100, 7, 0);
    step(1, 100, 9, 0);
    step(0, 100, 0, 0);
    chk("fwd_youngest", 64'(cpu_rdata), 64'(9));
    step(0, 104, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Wrap-around with alternating drain.
    for (int i = 0; i < 10; i++) step(1, 32'(200 + 4*(i%3)), 32'(i+50), 1'(i%2));
    for (int i = 0; i < 8; i++) step(0, 32'(200 + 4*(i%3)), 0, 1);

    // Coalescing pattern, then full buffer plus store to youngest address.
    step(1, 100, 7, 0);
    step(1, 100, 8, 0);
    step(1, 104, 1, 0);
    step(1, 108, 2, 0);
    step(1, 112, 3, 0);
    step(1, 112, 4, 0);
    step(0, 112, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Asynchronous reset with three stores pending.
    for (int i = 0; i < 3; i++) step(1, 32'(300 + 4*i), 32'(i), 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_wvalid", 64'(mem_wvalid), 64'(0));
    chk("arst_empty", 64'(empty), 64'(1));
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 300, 0, 1);

    // Random traffic over a small address set to exercise matches and wrap.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 99) < 60), 32'(4*$urandom_range(0, 5)),
           $urandom, 1'($urandom_range(0, 99) < 45));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store buffer between the single-cycle core's data port (MemWrite/DataAdr/WriteData/ReadData) and the data memory.
- Decouples core stores from a memory that accepts writes through a valid/ready handshake; stores are queued in an in-order FIFO and drained one per accepted handshake.
- Loads are served from the youngest matching buffered store, otherwise from memory, so the core always sees its own prior stores.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  core clock, rising-edge
reset  input  1  asynchronous, active-low reset
cpu_we  input  1  core store strobe (MemWrite)
cpu_addr  input  AW  core data address (DataAdr), used for both stores and loads
cpu_wdata  input  DW  core store data (WriteData)
cpu_rdata  output  DW  load data to core (ReadData)
cpu_stall  output  1  core must hold the current store; high = store not accepted
mem_raddr  output  AW  memory read address (= cpu_addr, combinational)
mem_rdata  input  DW  memory read data (combinational read)
mem_wvalid  output  1  head entry valid for drain
mem_waddr  output  AW  head entry address
mem_wdata  output  DW  head entry data
mem_wready  input  1  memory accepts head entry this cycle
empty  output  1  buffer holds no stores

Behaviour:
- Storage: DEPTH entries {addr, data}, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Reset (reset low, asynchronous): head=tail=count=0. Outputs: mem_wvalid=0, empty=1, cpu_stall=0. Entry contents are not reset.
- Push: cpu_we=1 and cpu_stall=0 writes {cpu_addr, cpu_wdata} at tail on the clock edge; tail+1, count+1. Stored one cycle after acceptance.
- cpu_stall = cpu_we & (count==DEPTH). It does not consider a same-cycle pop (no ready-to-stall combinational path). A stalled store is retried by the core holding cpu_we/cpu_addr/cpu_wdata.
- Drain: mem_wvalid = (count!=0). mem_waddr/mem_wdata = head entry. Pop on mem_wvalid & mem_wready: head+1, count-1. The outputs must be stable while mem_wvalid=1 and mem_wready=0.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Push into an empty buffer: the entry appears on mem_w* the next cycle. There is no same-cycle bypass, so the minimum store-to-memory latency is 1 cycle.
- Load forwarding (combinational):
  - Compare cpu_addr with every valid entry.
  - On one or more matches, cpu_rdata = data of the youngest match (closest to tail).
  - Otherwise cpu_rdata = mem_rdata.
  - Validity is computed from head/count and is wrap-aware.
  - An entry popped this cycle is still valid for forwarding this cycle.
- Full comparison over AW bits; no byte enables; stores are whole-word.
- empty = (count==0). The core or system uses it for fences/halt.
- Reset asserted mid-operation: all buffered stores are discarded immediately and mem_wvalid drops asynchronously.
- Memory write ordering equals core program order.

Optional Feature:
STORE_BUFFER_COALESCE_EN
- Defined:
  - A push whose cpu_addr equals the youngest valid entry's addr overwrites that entry's data. Tail and count are unchanged.
  - This applies only when that entry is not the head being popped this cycle (count>1, or no pop).
  - A coalescing store is accepted even when full (cpu_stall excludes this case).
- Undefined: every accepted store allocates a new entry, and the full rule applies unconditionally.

Test Plan:
- Reset low for 2 cycles, release; mem_wready=1; store addr 96 data 3, then addr 100 data 7 -> mem_w* shows (96,3) then (100,7) on consecutive cycles; empty=1 afterwards.
- mem_wready=0; 5 stores to 0,4,8,12,16 -> first 4 accepted, 5th sees cpu_stall=1 and is held; raise mem_wready for one cycle -> (0,x) drains, 5th store accepted next edge; drain order 0,4,8,12,16.
- mem_wready=0; store (100,7) then (100,9); load addr 100 -> cpu_rdata=9 (youngest); load addr 104 -> cpu_rdata=mem_rdata.
- Wrap-around: 10 stores with mem_wready toggling every cycle -> order preserved, count never exceeds 4, forwarding correct after pointer wrap.
- Fill to 3 entries, assert reset mid-drain -> mem_wvalid=0 and empty=1 immediately (before next clk edge); no further writes after release.
- With STORE_BUFFER_COALESCE_EN: mem_wready=0, store (100,7), (100,8) -> count=1, head data 8. Full buffer plus store to youngest addr -> cpu_stall=0 and data merged. Without the macro, the same stimulus gives count=2 and a stall when full.
